// File: rtl/kmeans_engine_param_if.sv
// Configuration, point-input and mean-output signal bundle of kmeans_engine_param.
// The engine attaches to the slave modport; the driving environment uses master.
interface kmeans_engine_param_if #(
  parameter int DIMS   = 3,
  parameter int UNIT_W = 8,
  parameter int K_MAX  = 16,
  parameter int N_MAX  = 100,
  parameter int ITER_W = 8
);
  localparam int KW = $clog2(K_MAX + 1);
  localparam int NW = $clog2(N_MAX + 1);
  localparam int IW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int PW = DIMS * UNIT_W;

  logic              cfg_valid;
  logic [KW-1:0]     cfg_k;
  logic [NW-1:0]     cfg_n;
  logic [ITER_W-1:0] cfg_max_iter;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [PW-1:0]     in_point;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_count;
  logic              out_valid;
  logic              out_ready;
  logic [IW-1:0]     out_idx;
  logic [PW-1:0]     out_mean;
  logic [NW-1:0]     out_count;

  modport master (
    output cfg_valid, cfg_k, cfg_n, cfg_max_iter, in_valid, in_point, out_ready,
    input  cfg_err, in_ready, busy, done, converged, iter_count,
           out_valid, out_idx, out_mean, out_count
  );

  modport slave (
    input  cfg_valid, cfg_k, cfg_n, cfg_max_iter, in_valid, in_point, out_ready,
    output cfg_err, in_ready, busy, done, converged, iter_count,
           out_valid, out_idx, out_mean, out_count
  );
endinterface

// File: rtl/kmeans_engine_param.sv
// Sequential k-means engine: buffers up to N_MAX points, iterates assign/accumulate/
// divide/check until means settle within THRESH or the iteration cap, then streams means.
module kmeans_engine_param #(
  parameter int DIMS   = 3,
  parameter int UNIT_W = 8,
  parameter int K_MAX  = 16,
  parameter int N_MAX  = 100,
  parameter int THRESH = 2,
  parameter int ITER_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  kmeans_engine_param_if.slave bus
);
  localparam int KW     = $clog2(K_MAX + 1);
  localparam int NW     = $clog2(N_MAX + 1);
  localparam int IW     = (K_MAX > 1) ? $clog2(K_MAX) : 1;
  localparam int PW     = DIMS * UNIT_W;
  localparam int ACC_W  = UNIT_W + $clog2(N_MAX);
  localparam int DIST_W = 2 * UNIT_W + $clog2(DIMS) + 1;
  localparam int CW     = $clog2(ACC_W + 1);
  localparam int DW     = (DIMS > 1) ? $clog2(DIMS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ASSIGN, S_ACC, S_DIV, S_CHECK, S_OUT, S_DONE
  } state_e;
  typedef logic [UNIT_W-1:0] coord_t;
  typedef logic [ACC_W:0]    wide_t;

  // Coordinate 0 sits in the MSBs of a packed point.
  function automatic coord_t coord_of(input logic [PW-1:0] v, input int d);
    return v[(DIMS-1-d)*UNIT_W +: UNIT_W];
  endfunction

  state_e            state_q;
  logic [KW-1:0]     cfg_k_q;
  logic [NW-1:0]     cfg_n_q, addr_q;
  logic [ITER_W-1:0] max_iter_q, iter_q;
  logic [IW-1:0]     j_q, best_idx_q, div_c_q, out_idx_q;
  logic [DIST_W-1:0] best_dist_q;
  logic [DW-1:0]     div_d_q;
  logic [CW-1:0]     div_step_q;
  logic [ACC_W-1:0]  quo_q, rem_q;
  logic [PW-1:0]     pts_q [N_MAX];
  logic [PW-1:0]     means_q [K_MAX];
  logic [PW-1:0]     new_means_q [K_MAX];
  logic [ACC_W-1:0]  acc_q [K_MAX][DIMS];
  logic [NW-1:0]     cnt_q [K_MAX];
  logic              cfg_err_q, in_ready_q, busy_q, done_q, converged_q, out_valid_q;
  logic [PW-1:0]     out_mean_q;
  logic [NW-1:0]     out_count_q;

  logic [DIST_W-1:0] dist_d;
  logic              conv_d, cfg_ok_d, last_c_d, load_beat_d;
  coord_t            step_d;
  logic [ACC_W-1:0]  quo_d, rem_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    coord_t                p, m, diff;
    logic [2*UNIT_W-1:0]   sq;
    logic [ACC_W-1:0]      dividend, rem_in;
    wide_t                 shifted, divisor;
    dist_d = '0;
    for (int d = 0; d < DIMS; d++) begin
      p      = coord_of(pts_q[addr_q], d);
      m      = coord_of(means_q[j_q], d);
      diff   = (p > m) ? p - m : m - p;
      sq     = {{UNIT_W{1'b0}}, diff} * {{UNIT_W{1'b0}}, diff};
      dist_d = dist_d + DIST_W'(sq);
    end

    conv_d = 1'b1;
    for (int jj = 0; jj < K_MAX; jj++) begin
      for (int d = 0; d < DIMS; d++) begin
        p    = coord_of(new_means_q[jj], d);
        m    = coord_of(means_q[jj], d);
        diff = (p > m) ? p - m : m - p;
        if (jj < int'(cfg_k_q) && diff > coord_t'(THRESH)) conv_d = 1'b0;
      end
    end

    // One restoring-division step; step 0 seeds the dividend straight from the accumulator.
    dividend = (div_step_q == '0) ? acc_q[div_c_q][div_d_q] : quo_q;
    rem_in   = (div_step_q == '0) ? '0 : rem_q;
    shifted  = {rem_in, dividend[ACC_W-1]};
    divisor  = wide_t'(cnt_q[div_c_q]);
    if (shifted >= divisor) begin
      rem_d = ACC_W'(shifted - divisor);
      quo_d = {dividend[ACC_W-2:0], 1'b1};
    end else begin
      rem_d = ACC_W'(shifted);
      quo_d = {dividend[ACC_W-2:0], 1'b0};
    end

    step_d      = (bus.cfg_k != '0) ? coord_t'({UNIT_W{1'b1}} / bus.cfg_k) : '0;
    cfg_ok_d    = (bus.cfg_k != '0) && (bus.cfg_k <= KW'(K_MAX)) &&
                  (bus.cfg_n != '0) && (bus.cfg_n <= NW'(N_MAX)) &&
                  (bus.cfg_max_iter != '0);
    last_c_d    = (KW'(div_c_q) == cfg_k_q - 1'b1);
    load_beat_d = (state_q == S_LOAD) && bus.in_valid && in_ready_q;
  end

  // NOTE: the point buffer has no reset; its contents are only read after being loaded.
  always_ff @(posedge clk) begin
    if (load_beat_d) pts_q[addr_q] <= bus.in_point;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees the old value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cfg_k_q     <= '0;
      cfg_n_q     <= '0;
      max_iter_q  <= '0;
      addr_q      <= '0;
      j_q         <= '0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
      div_c_q     <= '0;
      div_d_q     <= '0;
      div_step_q  <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      iter_q      <= '0;
      cfg_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      converged_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_mean_q  <= '0;
      out_count_q <= '0;
      for (int jj = 0; jj < K_MAX; jj++) begin
        means_q[jj]     <= '0;
        new_means_q[jj] <= '0;
        cnt_q[jj]       <= '0;
        for (int d = 0; d < DIMS; d++) acc_q[jj][d] <= '0;
      end
    end else begin
      cfg_err_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.cfg_valid && cfg_ok_d) begin
            cfg_k_q     <= bus.cfg_k;
            cfg_n_q     <= bus.cfg_n;
            max_iter_q  <= bus.cfg_max_iter;
            addr_q      <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            state_q     <= S_LOAD;
            for (int jj = 0; jj < K_MAX; jj++)
              for (int d = 0; d < DIMS; d++)
                means_q[jj][(DIMS-1-d)*UNIT_W +: UNIT_W] <= coord_t'(jj * int'(step_d));
          end else if (bus.cfg_valid) begin
            cfg_err_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_beat_d) begin
            if (addr_q == cfg_n_q - 1'b1) begin
              addr_q     <= '0;
              j_q        <= '0;
              iter_q     <= '0;
              in_ready_q <= 1'b0;
              state_q    <= S_ASSIGN;
              for (int jj = 0; jj < K_MAX; jj++) begin
                cnt_q[jj] <= '0;
                for (int d = 0; d < DIMS; d++) acc_q[jj][d] <= '0;
              end
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_ASSIGN: begin
          if (j_q == '0 || dist_d < best_dist_q) begin
            best_dist_q <= dist_d;
            best_idx_q  <= j_q;
          end
          if (KW'(j_q) == cfg_k_q - 1'b1) state_q <= S_ACC;
          else                             j_q     <= j_q + 1'b1;
        end
        S_ACC: begin
          for (int d = 0; d < DIMS; d++)
            acc_q[best_idx_q][d] <= acc_q[best_idx_q][d] + ACC_W'(coord_of(pts_q[addr_q], d));
          cnt_q[best_idx_q] <= cnt_q[best_idx_q] + 1'b1;
          j_q               <= '0;
          if (addr_q == cfg_n_q - 1'b1) begin
            div_c_q    <= '0;
            div_d_q    <= '0;
            div_step_q <= '0;
            state_q    <= S_DIV;
          end else begin
            addr_q  <= addr_q + 1'b1;
            state_q <= S_ASSIGN;
          end
        end
        S_DIV: begin
          if (cnt_q[div_c_q] == '0) begin
            new_means_q[div_c_q] <= means_q[div_c_q];
            if (last_c_d) state_q <= S_CHECK;
            else          div_c_q <= div_c_q + 1'b1;
          end else if (div_step_q == CW'(ACC_W - 1)) begin
            new_means_q[div_c_q][(DIMS-1-int'(div_d_q))*UNIT_W +: UNIT_W] <= coord_t'(quo_d);
            div_step_q <= '0;
            if (div_d_q == DW'(DIMS - 1)) begin
              div_d_q <= '0;
              if (last_c_d) state_q <= S_CHECK;
              else          div_c_q <= div_c_q + 1'b1;
            end else begin
              div_d_q <= div_d_q + 1'b1;
            end
          end else begin
            quo_q      <= quo_d;
            rem_q      <= rem_d;
            div_step_q <= div_step_q + 1'b1;
          end
        end
        S_CHECK: begin
          iter_q <= iter_q + 1'b1;
          for (int jj = 0; jj < K_MAX; jj++) means_q[jj] <= new_means_q[jj];
          if (conv_d || (iter_q + 1'b1) == max_iter_q) begin
            converged_q <= conv_d;
            out_valid_q <= 1'b1;
            out_idx_q   <= '0;
            out_mean_q  <= new_means_q[0];
            out_count_q <= cnt_q[0];
            state_q     <= S_OUT;
          end else begin
            addr_q  <= '0;
            j_q     <= '0;
            state_q <= S_ASSIGN;
            for (int jj = 0; jj < K_MAX; jj++) begin
              cnt_q[jj] <= '0;
              for (int d = 0; d < DIMS; d++) acc_q[jj][d] <= '0;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            if (KW'(out_idx_q) == cfg_k_q - 1'b1) begin
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              out_idx_q   <= out_idx_q + 1'b1;
              out_mean_q  <= means_q[out_idx_q + 1'b1];
              out_count_q <= cnt_q[out_idx_q + 1'b1];
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_err    = cfg_err_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.converged  = converged_q;
  assign bus.iter_count = iter_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.out_mean   = out_mean_q;
  assign bus.out_count  = out_count_q;
endmodule

// File: tb/tb_kmeans_engine_param.sv
// Self-checking bench for kmeans_engine_param: directed vector table, config rejects,
// mid-load reset, then randomized runs against a plain-arithmetic k-means model.
module tb_kmeans_engine_param;
  localparam int DIMS = 3, UNIT_W = 8, K_MAX = 16, N_MAX = 100, THRESH = 2, ITER_W = 8;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int NW = $clog2(N_MAX + 1);
  localparam int PW = DIMS * UNIT_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  kmeans_engine_param_if #(.DIMS(DIMS), .UNIT_W(UNIT_W), .K_MAX(K_MAX), .N_MAX(N_MAX),
                           .ITER_W(ITER_W)) bus ();
  kmeans_engine_param #(.DIMS(DIMS), .UNIT_W(UNIT_W), .K_MAX(K_MAX), .N_MAX(N_MAX),
                        .THRESH(THRESH), .ITER_W(ITER_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_pass = 0;
  int n_chk  = 0;
  bit abort  = 1'b0;
  int pt [N_MAX][DIMS];
  int exp_mean [K_MAX][DIMS];
  int exp_cnt [K_MAX];
  int exp_conv, exp_iter;

  typedef struct {
    int k, n, mi, bp;
    int pts [4];
    int mean [3];
    int cnt [3];
    int conv, iter;
  } vec_t;
  vec_t vecs [4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pack_pt(input int i);
    logic [PW-1:0] v = '0;
    for (int d = 0; d < DIMS; d++) v[(DIMS-1-d)*UNIT_W +: UNIT_W] = UNIT_W'(pt[i][d]);
    return v;
  endfunction

  // Reference: textbook Lloyd iteration on integers with the engine's start means.
  task automatic model(input int k, input int n, input int mi);
    int m [K_MAX][DIMS];
    int s [K_MAX][DIMS];
    int c [K_MAX];
    int it, best, bd, dd, nm;
    bit conv;
    for (int j = 0; j < k; j++)
      for (int d = 0; d < DIMS; d++) m[j][d] = j * ((2**UNIT_W - 1) / k);
    it = 0;
    do begin
      for (int j = 0; j < k; j++) begin
        c[j] = 0;
        for (int d = 0; d < DIMS; d++) s[j][d] = 0;
      end
      for (int p = 0; p < n; p++) begin
        best = 0;
        bd   = 0;
        for (int j = 0; j < k; j++) begin
          dd = 0;
          for (int d = 0; d < DIMS; d++) dd += (pt[p][d] - m[j][d]) * (pt[p][d] - m[j][d]);
          if (j == 0 || dd < bd) begin
            bd   = dd;
            best = j;
          end
        end
        c[best]++;
        for (int d = 0; d < DIMS; d++) s[best][d] += pt[p][d];
      end
      conv = 1'b1;
      for (int j = 0; j < k; j++)
        for (int d = 0; d < DIMS; d++) begin
          nm = (c[j] > 0) ? s[j][d] / c[j] : m[j][d];
          if ((nm > m[j][d] ? nm - m[j][d] : m[j][d] - nm) > THRESH) conv = 1'b0;
          m[j][d] = nm;
        end
      it++;
    end while (!conv && it < mi);
    exp_conv = conv;
    exp_iter = it;
    for (int j = 0; j < k; j++) begin
      exp_cnt[j] = c[j];
      for (int d = 0; d < DIMS; d++) exp_mean[j][d] = m[j][d];
    end
  endtask

  task automatic start(input int id, input int k, input int n, input int mi);
    bus.cfg_k        = KW'(k);
    bus.cfg_n        = NW'(n);
    bus.cfg_max_iter = ITER_W'(mi);
    bus.cfg_valid    = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    check($sformatf("run%0d accept_no_err", id), bus.cfg_err, 0);
    check($sformatf("run%0d done_cleared", id), bus.done, 0);
    check($sformatf("run%0d busy", id), bus.busy, 1);
  endtask

  task automatic load(input int n, input bit gaps, output bit ok);
    int bound;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_point = pack_pt(i);
      bound = 0;
      while (!bus.in_ready && bound < 8) begin
        tick();
        bound++;
      end
      if (!bus.in_ready) ok = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_case(input int id, input int k, input int n, input int mi,
                          input int bp, input bit gaps);
    logic [PW-1:0] got_mean [K_MAX];
    int            got_cnt [K_MAX];
    logic [PW-1:0] hold_mean, exp_p;
    logic [63:0]   hold_idx, hold_cnt;
    int got, budget;
    bit ok;
    if (abort) return;
    start(id, k, n, mi);
    load(n, gaps, ok);
    check($sformatf("run%0d in_ready_seen", id), ok, 1);
    check($sformatf("run%0d in_ready_drop", id), bus.in_ready, 0);
    got    = 0;
    budget = 20000;
    while (got < k && budget > 0) begin
      if (bus.out_valid) begin
        if (got == bp) begin
          hold_mean = bus.out_mean;
          hold_idx  = 64'(bus.out_idx);
          hold_cnt  = 64'(bus.out_count);
          repeat (5) begin
            tick();
            check($sformatf("run%0d bp_valid", id), bus.out_valid, 1);
            check($sformatf("run%0d bp_hold", id),
                  (bus.out_mean === hold_mean) && (64'(bus.out_idx) === hold_idx) &&
                  (64'(bus.out_count) === hold_cnt), 1);
          end
        end
        check($sformatf("run%0d out_idx", id), bus.out_idx, got);
        got_mean[got] = bus.out_mean;
        got_cnt[got]  = int'(bus.out_count);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        got++;
      end else begin
        tick();
        budget--;
      end
    end
    if (got < k) begin
      check($sformatf("run%0d out_timeout", id), got, k);
      abort = 1'b1;
      return;
    end
    check($sformatf("run%0d done", id), bus.done, 1);
    check($sformatf("run%0d converged", id), bus.converged, exp_conv);
    check($sformatf("run%0d iter_count", id), bus.iter_count, exp_iter);
    for (int j = 0; j < k; j++) begin
      exp_p = '0;
      for (int d = 0; d < DIMS; d++) exp_p[(DIMS-1-d)*UNIT_W +: UNIT_W] = UNIT_W'(exp_mean[j][d]);
      check($sformatf("run%0d mean[%0d]", id, j), got_mean[j], exp_p);
      check($sformatf("run%0d count[%0d]", id, j), got_cnt[j], exp_cnt[j]);
    end
  endtask

  task automatic reject(input string name, input int k, input int n, input int mi);
    bus.cfg_k        = KW'(k);
    bus.cfg_n        = NW'(n);
    bus.cfg_max_iter = ITER_W'(mi);
    bus.cfg_valid    = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    check({name, " cfg_err_pulse"}, bus.cfg_err, 1);
    check({name, " busy_low"}, bus.busy, 0);
    tick();
    check({name, " cfg_err_single"}, bus.cfg_err, 0);
  endtask

  initial begin
    int cen [K_MAX];
    int k, n, mi, c, v;
    bit ok;
    bus.cfg_valid    = 1'b0;
    bus.cfg_k        = '0;
    bus.cfg_n        = '0;
    bus.cfg_max_iter = '0;
    bus.in_valid     = 1'b0;
    bus.in_point     = '0;
    bus.out_ready    = 1'b0;

    vecs[0] = '{2, 4, 10, -1, '{10, 12, 200, 202}, '{11, 201, 0}, '{2, 2, 0}, 1, 2};
    vecs[1] = '{3, 2, 10, -1, '{1, 3, 0, 0}, '{2, 85, 170}, '{2, 0, 0}, 1, 1};
    vecs[2] = '{2, 4, 1, -1, '{10, 12, 200, 202}, '{11, 201, 0}, '{2, 2, 0}, 0, 1};
    vecs[3] = '{2, 4, 10, 1, '{10, 12, 200, 202}, '{11, 201, 0}, '{2, 2, 0}, 1, 2};

    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset in_ready", bus.in_ready, 0);

    reject("rej_k0", 0, 4, 10);
    reject("rej_kmax", K_MAX + 1, 4, 10);
    reject("rej_n", 2, N_MAX + 1, 10);
    reject("rej_iter0", 2, 4, 0);

    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < vecs[t].n; i++)
        for (int d = 0; d < DIMS; d++) pt[i][d] = vecs[t].pts[i];
      for (int j = 0; j < vecs[t].k; j++) begin
        exp_cnt[j] = vecs[t].cnt[j];
        for (int d = 0; d < DIMS; d++) exp_mean[j][d] = vecs[t].mean[j];
      end
      exp_conv = vecs[t].conv;
      exp_iter = vecs[t].iter;
      run_case(t, vecs[t].k, vecs[t].n, vecs[t].mi, vecs[t].bp, 1'b0);
    end

    // Reset mid-load after a finished run, with a non-zero iteration count held.
    start(90, 2, 4, 10);
    load(2, 1'b0, ok);
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("midreset busy", bus.busy, 0);
    check("midreset in_ready", bus.in_ready, 0);
    check("midreset out_valid", bus.out_valid, 0);
    check("midreset done", bus.done, 0);
    check("midreset iter_count", bus.iter_count, 0);

    for (int r = 0; r < 9; r++) begin
      if (r == 8) begin
        k  = K_MAX;
        n  = N_MAX;
        mi = 3;
      end else begin
        k  = $urandom_range(1, 6);
        n  = $urandom_range(1, 20);
        mi = $urandom_range(1, 6);
      end
      for (int j = 0; j < k; j++) cen[j] = $urandom_range(0, 255);
      for (int i = 0; i < n; i++) begin
        c = $urandom_range(0, k - 1);
        for (int d = 0; d < DIMS; d++) begin
          if (r % 2 == 0) v = $urandom_range(0, 255);
          else            v = cen[c] + $urandom_range(0, 10) - 5;
          pt[i][d] = (v < 0) ? 0 : (v > 255) ? 255 : v;
        end
      end
      model(k, n, mi);
      run_case(10 + r, k, n, mi, (r % 3 == 0) ? $urandom_range(0, k - 1) : -1, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/kmeans_engine_param.md
Name: kmeans_engine_param

Overview:
Parametrised successor to the fixed 3-D sequential k-means core. Buffers a configurable point set, iterates assign/accumulate/divide/check until converged or an iteration cap is reached, then streams final means and cluster sizes out over a valid/ready port. Dimension count, unit width, K and N limits, and convergence threshold are generics. Per-cluster K and N are set at run time. Convergence uses absolute differences.

Parameters:
DIMS, 3, coordinates per point (1..4)
UNIT_W, 8, bits per coordinate (unsigned)
K_MAX, 16, maximum clusters
N_MAX, 100, maximum points
THRESH, 2, per-coordinate convergence tolerance
ITER_W, 8, width of iteration cap/counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
cfg_valid  in  1  start request, sampled in IDLE only
cfg_k  in  clog2(K_MAX+1)  cluster count
cfg_n  in  clog2(N_MAX+1)  point count
cfg_max_iter  in  ITER_W  iteration cap
cfg_err  out  1  one-cycle pulse: config rejected
in_valid  in  1  point valid
in_ready  out  1  high in LOAD
in_point  in  DIMS*UNIT_W  point, coord 0 in MSBs
busy  out  1  high in any state except IDLE
done  out  1  level, high in DONE
converged  out  1  valid when done; 0 = cap hit
iter_count  out  ITER_W  iterations executed
out_valid  out  1  mean output valid
out_ready  in  1  sink ready
out_idx  out  clog2(K_MAX)  cluster index
out_mean  out  DIMS*UNIT_W  cluster mean
out_count  out  clog2(N_MAX+1)  points in cluster

Behaviour:
- Reset (reset=0 at clk edge, any state, including mid-run): state IDLE; all outputs 0; accumulators, counters, and iter_count cleared. Buffer contents are don't-care.
- Widths: ACC_W = UNIT_W + clog2(N_MAX). DIST_W = 2*UNIT_W + clog2(DIMS) + 1. All arithmetic is unsigned, and differences are absolute values, so there is no wrap.
- IDLE: on cfg_valid, reject if cfg_k is 0 or > K_MAX, cfg_n is 0 or > N_MAX, or cfg_max_iter is 0. On reject, pulse cfg_err and stay in IDLE. Otherwise latch the config, initialise mean j coords to j*floor((2^UNIT_W-1)/cfg_k), and go to LOAD.
- LOAD: in_ready = 1. Each in_valid&&in_ready beat writes point[addr] and increments addr. After beat cfg_n, in_ready drops the next cycle, then go to ASSIGN with addr = 0 and iter_count = 0.
- ASSIGN: one mean per cycle, for j = 0..cfg_k-1. Compute the squared Euclidean distance between point[addr] and mean j. Strict < keeps the minimum, so on a tie the lower index wins.
- ACC: add the point to acc[best] and increment cnt[best]. Then take the next point back to ASSIGN, or after the last point go to DIV.
- DIV: for each cluster with cnt > 0, divide each coord with a restoring divider (ACC_W cycles per coord). The quotient is truncated to UNIT_W. A cluster with cnt = 0 keeps its old mean.
- CHECK: increment iter_count. converged_flag = every |new - old| coord <= THRESH over all cfg_k clusters. Copy new means into means.
  - If converged_flag, or iter_count == cfg_max_iter, go to OUT. converged = converged_flag, and the flag wins if both hold on the same iteration.
  - Otherwise clear acc/cnt and go to ASSIGN with addr = 0.
- OUT: present clusters 0..cfg_k-1 in order. out_count is the final-iteration cnt. out_* is held stable while out_valid && !out_ready. Advance on handshake. After the last handshake go to DONE.
- DONE: done = 1; converged and iter_count are held. The next cfg_valid is treated as in IDLE (accept or reject), clears done, and starts a new run.
- in_valid outside LOAD, out_ready outside OUT, and cfg_valid outside IDLE/DONE are ignored.

Test Plan:
- Reset: hold reset=0 for 3 cycles in LOAD mid-stream -> next cycle busy=0, in_ready=0, out_valid=0, done=0, iter_count=0.
- Basic (DIMS=3, cfg_k=2, cfg_n=4, max_iter=10); points (10,10,10),(12,12,12),(200,200,200),(202,202,202) -> converged=1, iter_count=2; outputs idx0 (11,11,11) count 2, idx1 (201,201,201) count 2.
- Empty clusters: cfg_k=3, points (1,1,1),(3,3,3) -> idx0 (2,2,2) count 2; idx1 (85,85,85) count 0; idx2 (170,170,170) count 0; converged=1.
- Cap: basic data with cfg_max_iter=1 -> done with converged=0, iter_count=1, means (11,11,11),(201,201,201).
- Backpressure: hold out_ready=0 for 5 cycles during OUT -> out_valid=1 and out_idx/out_mean/out_count unchanged until the handshake; no cluster is skipped or repeated.
- Config reject: cfg_k=0, then cfg_n=N_MAX+1, then cfg_max_iter=0 -> cfg_err pulses one cycle each, busy stays 0; a valid config from DONE restarts the run with done=0.
